control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Moore-style fetch/decode/execute controller for the 32-bit single-bus datapath. Sequences all register in/out strobes, PC/IR/MAR/MDR/Y/Z/HI/LO enables and the ALU select so that exactly one source drives the bus per cycle. Talks to memory through a req/done handshake. Sits beside the datapath at CPU top level; IR contents feed back into it for decode.

Parameters:
MEM_TIMEOUT, 0, cycles to wait for mem_done before entering FAULT; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-low reset
run  in  1  start/continue execution; sampled only at instruction boundary
ir  in  32  current IR contents
mem_done  in  1  memory completed current mem_rd/mem_wr
reg_in  out  16  one-hot R0..R15 load enables
reg_out  out  16  one-hot R0..R15 bus drivers
pc_in, pc_out, inc_pc, ir_in, mar_in  out  1 each  datapath strobes
mdr_in, mdr_out, mdr_read  out  1 each  MDR load, bus drive, source select (1=memory, 0=bus)
y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, c_out  out  1 each  datapath strobes
alu_select  out  4  ADD=0 SUB=1 AND=2 OR=3 MUL=4 DIV=5
mem_rd, mem_wr  out  1 each  memory request, held until mem_done
busy  out  1  high in any state except IDLE/HALT/FAULT
halted  out  1  HALT state
fault  out  1  FAULT state (illegal opcode or timeout)
instr_count  out  CNT_W  instructions retired

Behaviour:
- Decode: opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15]. Opcodes: LD 00000, ST 00010, ADD 00011, SUB 00100, AND 00101, OR 00110, ADDI 01100, MUL 01111, DIV 10000, JR 10100, NOP 11010, HALT 11011; all others illegal.
- States: IDLE, T0..T7, HALT, FAULT. Reset (clear=0, async): state IDLE, all strobes/requests 0, alu_select 0, instr_count 0, flags 0.
- Strobes are pure decode of state, except mdr_in in memory-read steps (qualified by mem_done). At most one *_out/reg_out bit asserted per cycle.
- IDLE: run=1 -> T0, else stay. After each retire: run=1 -> T0, run=0 -> IDLE. Dropping run mid-instruction finishes the instruction.
- Fetch: T0 pc_out, mar_in, inc_pc, z_in. T1 zlow_out, pc_in, mem_rd; when mem_done=1, mdr_in and mdr_read=1, then -> T2; otherwise stay in T1. T2 mdr_out, ir_in.
- ADD/SUB/AND/OR: T3 reg_out[Rb], y_in. T4 reg_out[Rc], alu_select=op, z_in. T5 zlow_out, reg_in[Ra]; retire.
- ADDI: same as ADD with c_out instead of reg_out[Rc] in T4.
- LD: T3 reg_out[Rb], y_in. T4 c_out, ADD, z_in. T5 zlow_out, mar_in. T6 mem_rd; wait for mem_done, then mdr_in, mdr_read. T7 mdr_out, reg_in[Ra]; retire.
- ST: T3..T5 as LD. T6 reg_out[Ra], mdr_in, mdr_read=0. T7 mem_wr held until mem_done, then retire.
- MUL/DIV: T3 reg_out[Ra], y_in. T4 reg_out[Rb], alu_select, z_in. T5 zlow_out, lo_in. T6 zhigh_out, hi_in; retire.
- JR: T3 reg_out[Ra], pc_in; retire. NOP: retires after T2.
- HALT: T3 -> HALT state, sticky until reset; counted as retired.
- Illegal opcode: T3 -> FAULT, sticky until reset; not counted.
- Retire: instr_count increments on the retire cycle and wraps at 2^CNT_W.
- Wait counter: starts on entry to any wait state. MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT without mem_done -> FAULT, and mem_rd/mem_wr drop. mem_done outside a wait state is ignored. mem_done on the same cycle the timeout expires counts as completion.
- clear asserted mid-instruction aborts immediately to IDLE; any memory request drops asynchronously.

Optional Feature:
SINGLE_STEP_EN: adds input step (1 bit). When defined, leaving IDLE/retire toward T0 requires run=1 and a rising edge of step (edge-detect register). Exactly one instruction executes per step edge. When undefined, the port is absent and only run gates execution.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams
  - ALU select codes
  - state enum
  - IR field bit positions
- Sub-module decoder_4to16: combinational Ra/Rb/Rc to one-hot, instantiated once for reg_in and once for reg_out.

Test Plan:
- Reset, then run=1, mem_done one cycle after each request, ir=ADD R1,R2,R3 -> T0..T5 sequence; reg_out=0x0004 in T3, 0x0008 in T4; reg_in=0x0002 in T5; instr_count=1.
- LD R4,0x10(R5) with mem_done delayed 3 cycles -> mem_rd held 4 cycles in T6; mdr_in/mdr_read high only on the done cycle; reg_in=0x0010 in T7.
- MUL R6,R7 -> lo_in in T5 with zlow_out; hi_in in T6 with zhigh_out; alu_select=4 in T4.
- opcode 11111 -> fault=1, busy=0, instr_count unchanged; HALT -> halted=1, stays through run toggles.
- MEM_TIMEOUT=8, mem_done never asserts in T1 -> FAULT after 8 cycles, mem_rd drops to 0.
- Assert clear mid-T6 of ST -> all outputs 0 and state IDLE immediately; with SINGLE_STEP_EN, 3 step pulses -> instr_count=3.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the single-bus CPU control sequencer: opcode
// encodings, ALU select codes, sequencer state encoding and IR field
// positions. No ports; imported by control_sequencer.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd4;
    localparam logic [3:0] ALU_DIV = 4'd5;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT,
        S_FAULT
    } state_t;

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            OP_SUB:  alu_of = ALU_SUB;
            OP_AND:  alu_of = ALU_AND;
            OP_OR:   alu_of = ALU_OR;
            OP_MUL:  alu_of = ALU_MUL;
            OP_DIV:  alu_of = ALU_DIV;
            default: alu_of = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/decoder_4to16.sv
// decoder_4to16
// Combinational register-index to one-hot decoder.
// Ports:
//   sel    - register index 0..15
//   en     - when low, onehot is all zeros
//   onehot - one-hot select, bit sel set when en is high
module decoder_4to16 (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// Moore fetch/decode/execute controller for the 32-bit single-bus datapath.
// Drives every bus source/sink strobe so that at most one source owns the
// bus per cycle, and talks to memory with a mem_rd/mem_wr + mem_done
// handshake.
// Ports:
//   clock, clear (async, active low), run, ir[31:0], mem_done, step (only
//   with SINGLE_STEP_EN) -> inputs
//   reg_in/reg_out[15:0], pc/ir/mar/mdr/y/z/hi/lo strobes, c_out,
//   alu_select[3:0], mem_rd, mem_wr, busy, halted, fault,
//   instr_count[CNT_W-1:0] -> outputs
// Build option: SINGLE_STEP_EN adds the step input; each rising edge of
// step (with run high) releases exactly one instruction.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for run (and a step edge when single-stepping)
// T0     | PC -> MAR, PC+1 -> Z
// T1     | Z -> PC, memory read of instruction (wait state)
// T2     | MDR -> IR
// T3     | first execute step; JR/NOP/HALT retire, illegal -> FAULT
// T4..T7 | remaining execute steps; T6 (LD) and T7 (ST) are wait states
// HALT   | sticky stop after HALT instruction
// FAULT  | sticky stop after illegal opcode or memory timeout
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             mem_done,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic [15:0]      reg_in,
    output logic [15:0]      reg_out,
    output logic             pc_in,
    output logic             pc_out,
    output logic             inc_pc,
    output logic             ir_in,
    output logic             mar_in,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             mdr_read,
    output logic             y_in,
    output logic             z_in,
    output logic             zlow_out,
    output logic             zhigh_out,
    output logic             hi_in,
    output logic             lo_in,
    output logic             c_out,
    output logic [3:0]       alu_select,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    // Down-counter for memory waits: loaded outside wait states, expires at zero.
    localparam int       TW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit       TO_EN  = (MEM_TIMEOUT > 0);
    localparam logic [TW-1:0] TLOAD = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          state, state_nx;
    logic [4:0]      op;
    logic [3:0]      ra, rb, rc;
    logic [TW-1:0]   wait_cnt;
    logic            in_wait;
    logic            timeout;
    logic            go;
    logic            retire;
    logic            rin_en;
    logic            rout_en;
    logic [3:0]      rout_sel;
    logic            ir_unused;

    assign op        = ir[OPC_MSB:OPC_LSB];
    assign ra        = ir[RA_MSB:RA_LSB];
    assign rb        = ir[RB_MSB:RB_LSB];
    assign rc        = ir[RC_MSB:RC_LSB];
    assign ir_unused = ^ir[RC_LSB-1:0];

`ifdef SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // A step edge arriving mid-instruction is deliberately not remembered.
    assign go = run && step && !step_q;
`else
    assign go = run;
`endif

    assign in_wait = (state == S_T1)
                  || (state == S_T6 && op == OP_LD)
                  || (state == S_T7 && op == OP_ST);

    // mem_done on the expiring cycle wins, so completion is checked first.
    assign timeout = TO_EN && in_wait && !mem_done && (wait_cnt == '0);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wait_cnt <= TLOAD;
        end else if (!in_wait) begin
            wait_cnt <= TLOAD;
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - TW'(1);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            instr_count <= '0;
        end else begin
            state <= state_nx;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        retire     = 1'b0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rout_sel   = ra;
        pc_in      = 1'b0;
        pc_out     = 1'b0;
        inc_pc     = 1'b0;
        ir_in      = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        mdr_read   = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        zlow_out   = 1'b0;
        zhigh_out  = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        c_out      = 1'b0;
        alu_select = ALU_ADD;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;

        case (state)
            S_IDLE: begin
                if (go) state_nx = S_T0;
            end
            S_T0: begin
                pc_out   = 1'b1;
                mar_in   = 1'b1;
                inc_pc   = 1'b1;
                z_in     = 1'b1;
                state_nx = S_T1;
            end
            S_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                mem_rd   = 1'b1;
                if (mem_done) begin
                    mdr_in   = 1'b1;
                    mdr_read = 1'b1;
                    state_nx = S_T2;
                end else if (timeout) begin
                    state_nx = S_FAULT;
                end
            end
            S_T2: begin
                mdr_out  = 1'b1;
                ir_in    = 1'b1;
                state_nx = S_T3;
            end
            // IR is only valid from T3, so NOP and HALT resolve here.
            S_T3: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                        y_in     = 1'b1;
                        state_nx = S_T4;
                    end
                    OP_MUL, OP_DIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        y_in     = 1'b1;
                        state_nx = S_T4;
                    end
                    OP_JR: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        pc_in    = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_NOP, OP_HALT: retire = 1'b1;
                    default: state_nx = S_FAULT;
                endcase
            end
            S_T4: begin
                z_in       = 1'b1;
                alu_select = alu_of(op);
                state_nx   = S_T5;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        rout_en  = 1'b1;
                        rout_sel = rc;
                    end
                    OP_MUL, OP_DIV: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                    end
                    OP_ADDI, OP_LD, OP_ST: begin
                        c_out      = 1'b1;
                        alu_select = ALU_ADD;
                    end
                    default: begin
                        z_in     = 1'b0;
                        state_nx = S_FAULT;
                    end
                endcase
            end
            S_T5: begin
                zlow_out = 1'b1;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        rin_en = 1'b1;
                        retire = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        mar_in   = 1'b1;
                        state_nx = S_T6;
                    end
                    OP_MUL, OP_DIV: begin
                        lo_in    = 1'b1;
                        state_nx = S_T6;
                    end
                    default: begin
                        zlow_out = 1'b0;
                        state_nx = S_FAULT;
                    end
                endcase
            end
            S_T6: begin
                case (op)
                    OP_LD: begin
                        mem_rd = 1'b1;
                        if (mem_done) begin
                            mdr_in   = 1'b1;
                            mdr_read = 1'b1;
                            state_nx = S_T7;
                        end else if (timeout) begin
                            state_nx = S_FAULT;
                        end
                    end
                    OP_ST: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        mdr_in   = 1'b1;
                        state_nx = S_T7;
                    end
                    OP_MUL, OP_DIV: begin
                        zhigh_out = 1'b1;
                        hi_in     = 1'b1;
                        retire    = 1'b1;
                    end
                    default: state_nx = S_FAULT;
                endcase
            end
            S_T7: begin
                case (op)
                    OP_LD: begin
                        mdr_out = 1'b1;
                        rin_en  = 1'b1;
                        retire  = 1'b1;
                    end
                    OP_ST: begin
                        mem_wr = 1'b1;
                        if (mem_done) begin
                            retire = 1'b1;
                        end else if (timeout) begin
                            state_nx = S_FAULT;
                        end
                    end
                    default: state_nx = S_FAULT;
                endcase
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_nx = S_IDLE;
        endcase

        if (retire) begin
            if (op == OP_HALT) begin
                state_nx = S_HALT;
            end else if (go) begin
                state_nx = S_T0;
            end else begin
                state_nx = S_IDLE;
            end
        end

        busy = (state != S_IDLE) && (state != S_HALT) && (state != S_FAULT);
    end

    decoder_4to16 u_dec_in (
        .sel    (ra),
        .en     (rin_en),
        .onehot (reg_in)
    );

    decoder_4to16 u_dec_out (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (reg_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Directed-vector bench for control_sequencer (built with MEM_TIMEOUT=8).
// Inputs change 1 time unit after the falling edge; outputs are sampled
// there too, well away from the rising edge.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic        mem_done;
`ifdef SINGLE_STEP_EN
    logic        step;
`endif
    logic [15:0] reg_in, reg_out;
    logic        pc_in, pc_out, inc_pc, ir_in, mar_in;
    logic        mdr_in, mdr_out, mdr_read;
    logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, c_out;
    logic [3:0]  alu_select;
    logic        mem_rd, mem_wr, busy, halted, fault;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cycles;

    control_sequencer #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .run         (run),
        .ir          (ir),
        .mem_done    (mem_done),
`ifdef SINGLE_STEP_EN
        .step        (step),
`endif
        .reg_in      (reg_in),
        .reg_out     (reg_out),
        .pc_in       (pc_in),
        .pc_out      (pc_out),
        .inc_pc      (inc_pc),
        .ir_in       (ir_in),
        .mar_in      (mar_in),
        .mdr_in      (mdr_in),
        .mdr_out     (mdr_out),
        .mdr_read    (mdr_read),
        .y_in        (y_in),
        .z_in        (z_in),
        .zlow_out    (zlow_out),
        .zhigh_out   (zhigh_out),
        .hi_in       (hi_in),
        .lo_in       (lo_in),
        .c_out       (c_out),
        .alu_select  (alu_select),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Leaves the DUT in T0.
    task automatic begin_instr(input logic [31:0] v);
        ir  = v;
        run = 1'b1;
`ifdef SINGLE_STEP_EN
        step = 1'b1;
`endif
        tick();
        run = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        check_eq("t0_pc_out", pc_out, 1);
        check_eq("t0_busy", busy, 1);
    endtask

    // From T0: T1 with 'delay' cycles before mem_done, then T2. Leaves DUT in T2.
    task automatic fetch(input int delay);
        tick();
        for (int i = 0; i < delay; i++) begin
            check_eq("t1_wait_mem_rd", mem_rd, 1);
            check_eq("t1_wait_mdr_in", mdr_in, 0);
            tick();
        end
        check_eq("t1_mem_rd", mem_rd, 1);
        mem_done = 1'b1;
        #1;
        check_eq("t1_mdr_in", mdr_in, 1);
        check_eq("t1_mdr_read", mdr_read, 1);
        tick();
        mem_done = 1'b0;
        check_eq("t2_ir_in", ir_in, 1);
        check_eq("t2_mdr_out", mdr_out, 1);
    endtask

    task automatic recover();
        clear = 1'b0;
        #1;
        check_eq("clear_busy", busy, 0);
        tick();
        clear = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear    = 1'b0;
        run      = 1'b0;
        ir       = '0;
        mem_done = 1'b0;
`ifdef SINGLE_STEP_EN
        step     = 1'b0;
`endif
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_reg_out", {16'd0, reg_out}, 0);
        check_eq("rst_mem_rd", mem_rd, 0);
        check_eq("rst_count", instr_count, 0);
        check_eq("rst_alu", {28'd0, alu_select}, 0);
        clear = 1'b1;
        tick();
        check_eq("idle_no_run", busy, 0);

        // ADD R1,R2,R3
        begin_instr({OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0});
        fetch(1);
        tick();
        check_eq("add_t3_reg_out", {16'd0, reg_out}, 32'h0004);
        check_eq("add_t3_y_in", y_in, 1);
        tick();
        check_eq("add_t4_reg_out", {16'd0, reg_out}, 32'h0008);
        check_eq("add_t4_alu", {28'd0, alu_select}, 0);
        check_eq("add_t4_z_in", z_in, 1);
        tick();
        check_eq("add_t5_reg_in", {16'd0, reg_in}, 32'h0002);
        check_eq("add_t5_zlow", zlow_out, 1);
        tick();
        check_eq("add_idle", busy, 0);
        check_eq("add_count", instr_count, 1);

        // LD R4,0x10(R5), memory answers on the 4th T6 cycle
        begin_instr({OP_LD, 4'd4, 4'd5, 19'h10});
        fetch(1);
        tick();
        check_eq("ld_t3_reg_out", {16'd0, reg_out}, 32'h0020);
        tick();
        check_eq("ld_t4_c_out", c_out, 1);
        check_eq("ld_t4_reg_out", {16'd0, reg_out}, 0);
        tick();
        check_eq("ld_t5_mar_in", mar_in, 1);
        tick();
        rd_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_rd) rd_cycles++;
            check_eq("ld_t6_wait_mdr_in", mdr_in, 0);
            tick();
        end
        if (mem_rd) rd_cycles++;
        mem_done = 1'b1;
        #1;
        check_eq("ld_t6_mdr_in", mdr_in, 1);
        check_eq("ld_t6_mdr_read", mdr_read, 1);
        tick();
        mem_done = 1'b0;
        check_eq("ld_mem_rd_cycles", rd_cycles, 4);
        check_eq("ld_t7_reg_in", {16'd0, reg_in}, 32'h0010);
        check_eq("ld_t7_mdr_out", mdr_out, 1);
        tick();
        check_eq("ld_count", instr_count, 2);

        // MUL R6,R7
        begin_instr({OP_MUL, 4'd6, 4'd7, 19'd0});
        fetch(1);
        tick();
        check_eq("mul_t3_reg_out", {16'd0, reg_out}, 32'h0040);
        tick();
        check_eq("mul_t4_reg_out", {16'd0, reg_out}, 32'h0080);
        check_eq("mul_t4_alu", {28'd0, alu_select}, 4);
        tick();
        check_eq("mul_t5_lo_in", lo_in, 1);
        check_eq("mul_t5_zlow", zlow_out, 1);
        tick();
        check_eq("mul_t6_hi_in", hi_in, 1);
        check_eq("mul_t6_zhigh", zhigh_out, 1);
        tick();
        check_eq("mul_count", instr_count, 3);

        // ST R2,0x4(R3), full write
        begin_instr({OP_ST, 4'd2, 4'd3, 19'h4});
        fetch(1);
        tick();
        check_eq("st_t3_reg_out", {16'd0, reg_out}, 32'h0008);
        tick();
        tick();
        check_eq("st_t5_mar_in", mar_in, 1);
        tick();
        check_eq("st_t6_reg_out", {16'd0, reg_out}, 32'h0004);
        check_eq("st_t6_mdr_in", mdr_in, 1);
        check_eq("st_t6_mdr_read", mdr_read, 0);
        tick();
        check_eq("st_t7_mem_wr", mem_wr, 1);
        tick();
        check_eq("st_t7_mem_wr_held", mem_wr, 1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check_eq("st_mem_wr_drop", mem_wr, 0);
        check_eq("st_count", instr_count, 4);

        // ST aborted by clear in T6
        begin_instr({OP_ST, 4'd2, 4'd3, 19'h4});
        fetch(1);
        tick();
        tick();
        tick();
        tick();
        check_eq("st2_t6_mdr_in", mdr_in, 1);
        clear = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_reg_out", {16'd0, reg_out}, 0);
        check_eq("abort_mdr_in", mdr_in, 0);
        check_eq("abort_count", instr_count, 0);
        tick();
        clear = 1'b1;

        // Fetch timeout: no mem_done for 8 T1 cycles
        begin_instr({OP_NOP, 27'd0});
        tick();
        rd_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_rd) rd_cycles++;
            tick();
        end
        check_eq("to_mem_rd_cycles", rd_cycles, 8);
        check_eq("to_fault", fault, 1);
        check_eq("to_mem_rd_drop", mem_rd, 0);
        check_eq("to_busy", busy, 0);
        recover();

        // JR R9, then illegal opcode leaves the count alone
        begin_instr({OP_JR, 4'd9, 23'd0});
        fetch(1);
        tick();
        check_eq("jr_t3_reg_out", {16'd0, reg_out}, 32'h0200);
        check_eq("jr_t3_pc_in", pc_in, 1);
        tick();
        check_eq("jr_count", instr_count, 1);
        begin_instr(32'hF800_0000);
        fetch(1);
        tick();
        check_eq("ill_t3_reg_out", {16'd0, reg_out}, 0);
        tick();
        check_eq("ill_fault", fault, 1);
        check_eq("ill_busy", busy, 0);
        check_eq("ill_count", instr_count, 1);
        recover();

        // HALT is sticky through run toggles
        begin_instr({OP_HALT, 27'd0});
        fetch(1);
        tick();
        tick();
        check_eq("halt_halted", halted, 1);
        check_eq("halt_busy", busy, 0);
        check_eq("halt_count", instr_count, 1);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            tick();
            check_eq("halt_sticky", halted, 1);
        end
        run = 1'b0;
        recover();

        // mem_done on the last allowed T1 cycle counts as completion
        begin_instr({OP_NOP, 27'd0});
        fetch(7);
        check_eq("edge_no_fault", fault, 0);
        tick();
        check_eq("nop_t3_busy", busy, 1);
        tick();
        check_eq("nop_idle", busy, 0);
        check_eq("nop_count", instr_count, 1);

`ifdef SINGLE_STEP_EN
        recover();
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("step_no_edge_idle", busy, 0);
        end
        for (int p = 0; p < 3; p++) begin
            ir   = {OP_NOP, 27'd0};
            step = 1'b1;
            tick();
            step = 1'b0;
            check_eq("step_t0", pc_out, 1);
            fetch(1);
            tick();
            tick();
            check_eq("step_back_idle", busy, 0);
        end
        check_eq("step_count", instr_count, 3);
        run = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
